// File: rtl/mem_access_unit_if.sv
// Data-memory request/ready bus between the MEM-stage access unit and data memory.
// The access unit is the master; the memory (or its model) is the slave.
interface mem_access_unit_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wstrb,
        output dm_wdata,
        input  dm_rdata,
        input  dm_ready
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wstrb,
        input  dm_wdata,
        output dm_rdata,
        output dm_ready
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: request/ready handshake with data memory, load
// right-alignment, store strobes/lane replication and misaligned-access detection.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no transaction; decode the EX/MEM command each cycle
// ST_WAIT | request outstanding, bus held stable until dm_ready
// ST_DONE | one-cycle completion; pipeline advances, ld_valid for loads
module mem_access_unit (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_rd,
    input  logic                      mem_wr,
    input  logic [2:0]                fun_3,
    input  logic [31:0]               addr,
    input  logic [31:0]               st_data,
    mem_access_unit_if.master         dm,
    output logic [31:0]               ld_data,
    output logic                      ld_valid,
    output logic                      stall,
    output logic                      misalign
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        op;
    logic        bad;
    logic        start;
    logic        finish;
    logic        mis_set;
    logic        is_load;
    logic [1:0]  off;
    logic [3:0]  wstrb_dec;
    logic [31:0] wdata_dec;

    // Sign/zero extension of loads is done by the downstream filter.
    logic        unused_fun3_sign;
    assign unused_fun3_sign = fun_3[2];

    assign op = mem_rd | mem_wr;

    always_comb begin
        bad = 1'b0;
        case (fun_3[1:0])
            2'b01:   bad = addr[0];
            2'b10:   bad = |addr[1:0];
            default: bad = 1'b0;
        endcase
    end

    always_comb begin
        wstrb_dec = 4'b0000;
        wdata_dec = 32'h0000_0000;
        if (mem_wr) begin
            case (fun_3[1:0])
                2'b01: begin
                    wstrb_dec = 4'b0011 << addr[1:0];
                    wdata_dec = {2{st_data[15:0]}};
                end
                2'b10: begin
                    wstrb_dec = 4'b1111;
                    wdata_dec = st_data;
                end
                default: begin
                    wstrb_dec = 4'b0001 << addr[1:0];
                    wdata_dec = {4{st_data[7:0]}};
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        mis_set   = 1'b0;
        stall     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op && !bad) begin
                    start     = 1'b1;
                    stall     = 1'b1;
                    state_nxt = ST_WAIT;
                end else if (op && bad) begin
                    mis_set = 1'b1;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (dm.dm_ready) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dm.dm_req   <= 1'b0;
            dm.dm_we    <= 1'b0;
            dm.dm_addr  <= 32'h0000_0000;
            dm.dm_wstrb <= 4'b0000;
            dm.dm_wdata <= 32'h0000_0000;
            ld_data     <= 32'h0000_0000;
            ld_valid    <= 1'b0;
            misalign    <= 1'b0;
            is_load     <= 1'b0;
            off         <= 2'b00;
        end else begin
            misalign <= mis_set;
            ld_valid <= finish & is_load;
            if (start) begin
                dm.dm_req   <= 1'b1;
                dm.dm_we    <= mem_wr;
                dm.dm_addr  <= {addr[31:2], 2'b00};
                dm.dm_wstrb <= wstrb_dec;
                dm.dm_wdata <= wdata_dec;
                is_load     <= mem_rd;
                off         <= addr[1:0];
            end
            if (finish) begin
                dm.dm_req <= 1'b0;
                if (is_load) begin
                    ld_data <= dm.dm_rdata >> {off, 3'b000};
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a transaction-level model predicts every
// output per cycle, plus literal checks of the directed load/store scenarios.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  fun_3;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        stall;
    logic        misalign;

    mem_access_unit_if dm_bus ();

    mem_access_unit dut (
        .clk      (clk),
        .rst      (rst),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .fun_3    (fun_3),
        .addr     (addr),
        .st_data  (st_data),
        .dm       (dm_bus),
        .ld_data  (ld_data),
        .ld_valid (ld_valid),
        .stall    (stall),
        .misalign (misalign)
    );

    int checks = 0;
    int errors = 0;

    logic        e_check = 1'b0;
    logic        e_stall, e_req, e_we, e_ld_valid, e_mis;
    logic [31:0] e_addr, e_wdata, e_ld_data;
    logic [3:0]  e_wstrb;

    logic [31:0] m_ld_data;
    logic        m_mis_next;

    int          stall_cnt, req_cnt, ldv_cnt, mis_cnt;
    logic [31:0] cap_addr, cap_wdata, cap_ld;
    logic [3:0]  cap_wstrb;
    logic        cap_we;

    logic [2:0]  ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int size_of(logic [2:0] f);
        case (f[1:0])
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 1;
        endcase
    endfunction

    always @(negedge clk) begin
        if (stall === 1'b1) stall_cnt++;
        if (misalign === 1'b1) mis_cnt++;
        if (dm_bus.dm_req === 1'b1) begin
            req_cnt++;
            cap_addr  = dm_bus.dm_addr;
            cap_wstrb = dm_bus.dm_wstrb;
            cap_wdata = dm_bus.dm_wdata;
            cap_we    = dm_bus.dm_we;
        end
        if (ld_valid === 1'b1) begin
            ldv_cnt++;
            cap_ld = ld_data;
        end
        if (e_check) begin
            chk("stall",    32'(stall),         32'(e_stall));
            chk("dm_req",   32'(dm_bus.dm_req), 32'(e_req));
            chk("ld_valid", 32'(ld_valid),      32'(e_ld_valid));
            chk("ld_data",  ld_data,            e_ld_data);
            chk("misalign", 32'(misalign),      32'(e_mis));
            if (e_req) begin
                chk("dm_we",    32'(dm_bus.dm_we),    32'(e_we));
                chk("dm_addr",  dm_bus.dm_addr,       e_addr);
                chk("dm_wstrb", 32'(dm_bus.dm_wstrb), 32'(e_wstrb));
                chk("dm_wdata", dm_bus.dm_wdata,      e_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall_cnt = 0;
        req_cnt   = 0;
        ldv_cnt   = 0;
        mis_cnt   = 0;
        cap_ld    = 32'hXXXX_XXXX;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_rd = 1'b0; mem_wr = 1'b0; fun_3 = 3'b000; addr = 32'h0; st_data = 32'h0;
        dm_bus.dm_ready = 1'b0; dm_bus.dm_rdata = 32'h0;
        e_check = 1'b0;
        step();
        step();
        m_ld_data = 32'h0; m_mis_next = 1'b0;
        e_stall = 1'b0; e_req = 1'b0; e_ld_valid = 1'b0; e_ld_data = 32'h0; e_mis = 1'b0;
        e_we = 1'b0; e_addr = 32'h0; e_wstrb = 4'h0; e_wdata = 32'h0;
        e_check = 1'b1;
        chk("reset_dm_req",   32'(dm_bus.dm_req),   32'h0);
        chk("reset_dm_we",    32'(dm_bus.dm_we),    32'h0);
        chk("reset_dm_addr",  dm_bus.dm_addr,       32'h0);
        chk("reset_dm_wstrb", 32'(dm_bus.dm_wstrb), 32'h0);
        chk("reset_dm_wdata", dm_bus.dm_wdata,      32'h0);
        rst = 1'b0;
    endtask

    // One instruction: d = memory wait cycles before dm_ready, rdv = word returned,
    // rst_at = WAIT cycle index (1-based) at which reset is asserted, -1 for none.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input int d,
                         input logic [31:0] rdv, input int rst_at);
        int          sz;
        int          off;
        int          pick;
        logic        op;
        logic        bad;
        logic [3:0]  xs;
        logic [31:0] xw;
        op  = rd | wr;
        sz  = size_of(f3);
        off = int'(a[1:0]);
        bad = op && ((off % sz) != 0);

        mem_rd = rd; mem_wr = wr; fun_3 = f3; addr = a; st_data = sd;
        dm_bus.dm_ready = 1'($urandom);
        dm_bus.dm_rdata = $urandom;
        e_stall = op && !bad; e_req = 1'b0; e_ld_valid = 1'b0;
        e_ld_data = m_ld_data; e_mis = m_mis_next;
        step();
        m_mis_next = bad;
        if (!op || bad) return;

        xs = 4'h0;
        xw = 32'h0;
        if (wr) begin
            xs = 4'(((1 << sz) - 1) << off);
            for (int i = 0; i < 4; i++) xw[8*i +: 8] = sd[8*(i % sz) +: 8];
        end

        for (int k = 1; k <= d + 1; k++) begin
            dm_bus.dm_rdata = (k == d + 1) ? rdv : $urandom;
            dm_bus.dm_ready = (k == d + 1) && (k != rst_at);
            if (k == rst_at) rst = 1'b1;
            e_stall = 1'b1; e_req = 1'b1; e_we = wr; e_addr = {a[31:2], 2'b00};
            e_wstrb = xs; e_wdata = xw; e_ld_valid = 1'b0;
            e_ld_data = m_ld_data; e_mis = 1'b0;
            step();
            if (k == rst_at) begin
                rst = 1'b0;
                m_ld_data = 32'h0; m_mis_next = 1'b0;
                mem_rd = 1'b0; mem_wr = 1'b0;
                e_stall = 1'b0; e_req = 1'b0; e_ld_valid = 1'b0;
                e_ld_data = 32'h0; e_mis = 1'b0;
                chk("wait_reset_dm_addr", dm_bus.dm_addr, 32'h0);
                step();
                return;
            end
        end

        if (rd) m_ld_data = rdv >> (8 * off);
        pick = $urandom_range(0, 2);
        mem_rd = (pick == 1); mem_wr = (pick == 2);
        fun_3 = 3'($urandom); addr = $urandom; st_data = $urandom;
        dm_bus.dm_ready = 1'($urandom);
        dm_bus.dm_rdata = $urandom;
        e_stall = 1'b0; e_req = 1'b0; e_ld_valid = rd;
        e_ld_data = m_ld_data; e_mis = 1'b0;
        step();
        m_mis_next = 1'b0;
    endtask

    initial begin
        int          kind;
        int          d;
        int          ra;
        logic [2:0]  f;

        do_reset();

        clr();
        do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, -1);
        chk("lw_stall_cycles", 32'(stall_cnt), 32'd2);
        chk("lw_dm_addr",      cap_addr,       32'h100);
        chk("lw_dm_wstrb",     32'(cap_wstrb), 32'h0);
        chk("lw_ld_data",      cap_ld,         32'hDEADBEEF);

        clr();
        do_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 3, 32'h80AABBCC, -1);
        chk("lb_stall_cycles", 32'(stall_cnt), 32'd5);
        chk("lb_ld_data",      cap_ld,         32'h00000080);

        clr();
        do_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'h0, -1);
        chk("sh_dm_we",    32'(cap_we),    32'h1);
        chk("sh_dm_addr",  cap_addr,       32'h200);
        chk("sh_dm_wstrb", 32'(cap_wstrb), 32'hC);
        chk("sh_dm_wdata", cap_wdata,      32'hABCDABCD);
        chk("sh_no_ld_valid", 32'(ldv_cnt), 32'd0);

        clr();
        do_op(1'b0, 1'b1, 3'b000, 32'h301, 32'h000000EF, 0, 32'h0, -1);
        chk("sb_dm_wstrb", 32'(cap_wstrb), 32'h2);
        chk("sb_dm_wdata", cap_wdata,      32'hEFEFEFEF);

        clr();
        do_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0, -1);
        chk("mis_no_req",   32'(req_cnt),   32'd0);
        chk("mis_no_stall", 32'(stall_cnt), 32'd0);
        do_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1, 32'h11223344, -1);
        chk("mis_pulse_cycles", 32'(mis_cnt), 32'd1);
        chk("after_mis_ld",     cap_ld,       32'h11223344);

        clr();
        do_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5, 32'h0, 2);
        chk("rst_wait_no_ld_valid", 32'(ldv_cnt), 32'd0);
        clr();
        do_op(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 1, 32'h55AA1234, -1);
        chk("after_rst_ld",       cap_ld,         32'h55AA1234);
        chk("after_rst_ld_valid", 32'(ldv_cnt),   32'd1);

        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 4);
            d    = $urandom_range(0, 3);
            ra   = ($urandom_range(0, 24) == 0) ? $urandom_range(1, d + 1) : -1;
            if (kind == 0) begin
                do_op(1'b0, 1'b0, 3'($urandom), $urandom, $urandom, 0, 32'h0, -1);
            end else if (kind <= 2) begin
                f = ld_codes[$urandom_range(0, 4)];
                do_op(1'b1, 1'b0, f, $urandom, $urandom, d, $urandom, ra);
            end else begin
                f = 3'($urandom_range(0, 2));
                do_op(1'b0, 1'b1, f, $urandom, $urandom, d, 32'h0, ra);
            end
        end
        do_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0, 32'h0, -1);

        e_check = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
